coresysservices_ahbl_txn_seq: RTL and testbench

Transaction sequencer that sits directly upstream of the AHB-Lite master interface and drives its fmh* backend port. It accepts word-sized read/write commands of 1–16 beats from the service FSM and generates AHB-Lite address/data phases with pipelining, wait-state handling, 1 KB boundary handling and two-cycle ERROR abort. It returns read data and per-beat status to the requester.

---
 rtl/coresysservices_ahbl_txn_seq.sv | 206 ++++++++++++++++++++
 tb/tb_coresysservices_ahbl_txn_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/coresysservices_ahbl_txn_seq.sv
// +----------------------------------------------------------------------------+
// | coresysservices_ahbl_txn_seq                                               |
// | Word-sized 1..16 beat command sequencer driving an AHB-Lite master port.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module coresysservices_ahbl_txn_seq #(
  parameter int MAX_BEATS = 16
) (
  input  logic                          HCLK,
  input  logic                          HRESETN,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic                          req_write_i,
  input  logic [31:0]                   req_addr_i,
  input  logic [$clog2(MAX_BEATS)-1:0]  req_len_i,
  input  logic [31:0]                   wd_data_i,
  output logic                          wd_ack_o,
  output logic                          rsp_valid_o,
  output logic [31:0]                   rsp_rdata_o,
  output logic                          rsp_err_o,
  output logic                          rsp_last_o,
  output logic                          fmhsel_o,
  output logic [1:0]                    fmhtrans_o,
  output logic                          fmhwrite_o,
  output logic [2:0]                    fmhsize_o,
  output logic [2:0]                    fmhburst_o,
  output logic [31:0]                   fmhaddr_o,
  output logic [31:0]                   fmhwdata_o,
  input  logic                          mfhready_i,
  input  logic                          mfhresp_i,
  input  logic [31:0]                   mfhrdata_i
);

  localparam int         C_LW         = $clog2(MAX_BEATS);
  localparam int         C_CW         = C_LW + 1;
  localparam logic [1:0] C_HT_IDLE    = 2'b00;
  localparam logic [1:0] C_HT_NONSEQ  = 2'b10;
  localparam logic [1:0] C_HT_SEQ     = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_LAST = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t            r_state, w_state;
  logic              r_sel, w_sel;
  logic [1:0]        r_trans, w_trans;
  logic              r_write, w_write;
  logic [2:0]        r_burst, w_burst;
  logic [31:0]       r_addr, w_addr;
  logic [31:0]       r_wdata, w_wdata;
  logic [C_CW-1:0]   r_left, w_left;
  logic              r_dp, w_dp;
  logic              r_rsp_valid, w_rsp_valid;
  logic [31:0]       r_rsp_rdata, w_rsp_rdata;
  logic              r_rsp_err, w_rsp_err;
  logic              r_rsp_last, w_rsp_last;
  logic [31:0]       w_addr_inc;

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      r_state     <= S_IDLE;
      r_sel       <= 1'b0;
      r_trans     <= C_HT_IDLE;
      r_write     <= 1'b0;
      r_burst     <= 3'b000;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_left      <= '0;
      r_dp        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
      r_rsp_last  <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_sel       <= w_sel;
      r_trans     <= w_trans;
      r_write     <= w_write;
      r_burst     <= w_burst;
      r_addr      <= w_addr;
      r_wdata     <= w_wdata;
      r_left      <= w_left;
      r_dp        <= w_dp;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_rdata <= w_rsp_rdata;
      r_rsp_err   <= w_rsp_err;
      r_rsp_last  <= w_rsp_last;
    end
  end

  // r_dp marks a data phase in flight behind the current address phase.
  always_comb begin
    w_state     = r_state;
    w_sel       = r_sel;
    w_trans     = r_trans;
    w_write     = r_write;
    w_burst     = r_burst;
    w_addr      = r_addr;
    w_wdata     = r_wdata;
    w_left      = r_left;
    w_dp        = r_dp;
    w_rsp_valid = 1'b0;
    w_rsp_rdata = r_rsp_rdata;
    w_rsp_err   = 1'b0;
    w_rsp_last  = 1'b0;
    w_addr_inc  = r_addr + 32'd4;
    case (r_state)
      S_IDLE: begin
        if (req_valid_i) begin
          w_state = S_XFER;
          w_sel   = 1'b1;
          w_trans = C_HT_NONSEQ;
          w_write = req_write_i;
          w_burst = (req_len_i == '0) ? 3'b000 : 3'b001;
          w_addr  = req_addr_i & 32'hFFFF_FFFC;
          w_left  = C_CW'(req_len_i) + C_CW'(1);
          w_dp    = 1'b0;
        end
      end
      S_XFER: begin
        if (mfhready_i) begin
          if (r_dp) begin
            w_rsp_valid = 1'b1;
            w_rsp_err   = mfhresp_i;
            w_rsp_last  = mfhresp_i;
            w_rsp_rdata = (r_write || mfhresp_i) ? 32'd0 : mfhrdata_i;
          end
          if (r_dp && mfhresp_i) begin
            w_state = S_IDLE;
            w_sel   = 1'b0;
            w_trans = C_HT_IDLE;
            w_dp    = 1'b0;
          end else begin
            w_addr = w_addr_inc;
            w_left = r_left - C_CW'(1);
            w_dp   = 1'b1;
            if (r_write) w_wdata = wd_data_i;
            if (r_left == C_CW'(1)) begin
              w_state = S_LAST;
              w_trans = C_HT_IDLE;
            end else begin
              // A 1 KB crossing restarts the burst with NONSEQ.
              w_trans = (w_addr_inc[9:0] == 10'd0) ? C_HT_NONSEQ : C_HT_SEQ;
            end
          end
        end else if (r_dp && mfhresp_i) begin
          w_state = S_ERR;
          w_trans = C_HT_IDLE;
        end
      end
      S_LAST: begin
        if (mfhready_i) begin
          w_rsp_valid = 1'b1;
          w_rsp_last  = 1'b1;
          w_rsp_err   = mfhresp_i;
          w_rsp_rdata = (r_write || mfhresp_i) ? 32'd0 : mfhrdata_i;
          w_state     = S_IDLE;
          w_sel       = 1'b0;
          w_dp        = 1'b0;
        end else if (mfhresp_i) begin
          w_state = S_ERR;
        end
      end
      S_ERR: begin
        w_trans = C_HT_IDLE;
        if (mfhready_i) begin
          w_rsp_valid = 1'b1;
          w_rsp_err   = 1'b1;
          w_rsp_last  = 1'b1;
          w_rsp_rdata = 32'd0;
          w_state     = S_IDLE;
          w_sel       = 1'b0;
          w_dp        = 1'b0;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_sel   = 1'b0;
        w_trans = C_HT_IDLE;
      end
    endcase
  end

  assign req_ready_o = (r_state == S_IDLE);
  assign wd_ack_o    = (r_state == S_XFER) && r_write && mfhready_i;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_err_o   = r_rsp_err;
  assign rsp_last_o  = r_rsp_last;
  assign fmhsel_o    = r_sel;
  assign fmhtrans_o  = r_trans;
  assign fmhwrite_o  = r_write;
  assign fmhsize_o   = 3'b010;
  assign fmhburst_o  = r_burst;
  assign fmhaddr_o   = r_addr;
  assign fmhwdata_o  = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_coresysservices_ahbl_txn_seq.sv
// +----------------------------------------------------------------------------+
// | tb_coresysservices_ahbl_txn_seq                                            |
// | Vector table, corner sequences and random commands against a beat model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_coresysservices_ahbl_txn_seq;

  logic        HCLK = 1'b0;
  logic        HRESETN = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_write_i = 1'b0;
  logic [31:0] req_addr_i = 32'd0;
  logic [3:0]  req_len_i = 4'd0;
  logic [31:0] wd_data_i = 32'd0;
  logic        mfhready_i = 1'b1;
  logic        mfhresp_i = 1'b0;
  logic [31:0] mfhrdata_i = 32'd0;
  logic        req_ready_o, wd_ack_o, rsp_valid_o, rsp_err_o, rsp_last_o;
  logic [31:0] rsp_rdata_o, fmhaddr_o, fmhwdata_o;
  logic        fmhsel_o, fmhwrite_o;
  logic [1:0]  fmhtrans_o;
  logic [2:0]  fmhsize_o, fmhburst_o;

  always #5 HCLK = ~HCLK;

  coresysservices_ahbl_txn_seq #(.MAX_BEATS(16)) dut (
    .HCLK(HCLK), .HRESETN(HRESETN),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_len_i(req_len_i),
    .wd_data_i(wd_data_i), .wd_ack_o(wd_ack_o),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .rsp_last_o(rsp_last_o),
    .fmhsel_o(fmhsel_o), .fmhtrans_o(fmhtrans_o), .fmhwrite_o(fmhwrite_o), .fmhsize_o(fmhsize_o),
    .fmhburst_o(fmhburst_o), .fmhaddr_o(fmhaddr_o), .fmhwdata_o(fmhwdata_o),
    .mfhready_i(mfhready_i), .mfhresp_i(mfhresp_i), .mfhrdata_i(mfhrdata_i)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    int          len;
    int          waits;
    int          err_beat;
    int          exp_nrsp;
    int          exp_cyc;
  } vec_t;

  vec_t        tbl[7];
  int          n_checks = 0;
  int          n_errs = 0;
  logic [31:0] wr_data[16];
  logic [31:0] rd_data[16];
  int          wait_cnt[16];
  int          obs_nrsp, obs_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_sel"},   32'(fmhsel_o), 32'd0);
    check({tag, "_trans"}, 32'(fmhtrans_o), 32'd0);
    check({tag, "_write"}, 32'(fmhwrite_o), 32'd0);
    check({tag, "_burst"}, 32'(fmhburst_o), 32'd0);
    check({tag, "_size"},  32'(fmhsize_o), 32'd2);
    check({tag, "_addr"},  fmhaddr_o, 32'd0);
    check({tag, "_wdata"}, fmhwdata_o, 32'd0);
    check({tag, "_rsp"},   {rsp_valid_o, rsp_err_o, rsp_last_o}, 32'd0);
    check({tag, "_rdata"}, rsp_rdata_o, 32'd0);
    check({tag, "_ack"},   32'(wd_ack_o), 32'd0);
    check({tag, "_ready"}, 32'(req_ready_o), 32'd1);
  endtask

  // Runs one command against a beat-level slave model.  Expected beats follow
  // directly from the command: beat b lives at base+4b, is NONSEQ at b==0 or a
  // 1 KB boundary, and the command ends at the error beat or at beat len.
  task automatic run_cmd(input bit wr, input logic [31:0] addr, input int len, input int err_beat,
                         input bit pre, input bit hold, input int abort_after);
    logic [31:0] base, ea;
    logic [1:0]  et;
    int n, n_eff, exp_cyc, a_idx, r_idx, ack_n, cyc, dp_beat, wl, nb;
    bit dp_act, errph, got_last, new_dp, e_err, e_last, e_ack;
    base  = addr & 32'hFFFF_FFFC;
    n     = len + 1;
    n_eff = (err_beat >= 0 && err_beat < n) ? err_beat + 1 : n;
    exp_cyc = n_eff + 2 + ((n_eff != n || err_beat == len) ? 1 : 0);
    for (int b = 0; b < n_eff; b++) if (b != err_beat) exp_cyc += wait_cnt[b];
    a_idx = 0; r_idx = 0; ack_n = 0; cyc = 0; dp_beat = 0; wl = 0; nb = 0;
    dp_act = 0; errph = 0; got_last = 0;
    if (!pre) begin
      @(negedge HCLK);
      req_valid_i = 1'b1;
      req_write_i = wr;
      req_addr_i  = base | 32'($urandom_range(0, 3));
      req_len_i   = 4'(len);
      mfhready_i  = 1'b1;
      mfhresp_i   = 1'b0;
      #1 check("ready_before_accept", 32'(req_ready_o), 32'd1);
    end
    while (!got_last && cyc < 400) begin
      @(negedge HCLK);
      cyc++;
      if (!hold) req_valid_i = 1'b0;
      mfhrdata_i = $urandom;
      mfhresp_i  = 1'b0;
      mfhready_i = 1'b1;
      if (dp_act) begin
        if (dp_beat == err_beat) begin
          mfhresp_i  = 1'b1;
          mfhready_i = errph;
        end else if (wl > 0) begin
          mfhready_i = 1'b0;
        end else begin
          mfhrdata_i = rd_data[dp_beat];
        end
      end
      wd_data_i = (ack_n < 16) ? wr_data[ack_n] : $urandom;
      #1;
      if (rsp_valid_o) begin
        check("rsp_in_range", 32'(r_idx < n_eff), 32'd1);
        if (r_idx < n_eff) begin
          e_err  = (r_idx == err_beat);
          e_last = (r_idx == n_eff - 1);
          check("rsp_err", 32'(rsp_err_o), 32'(e_err));
          check("rsp_last", 32'(rsp_last_o), 32'(e_last));
          if (!e_err) check("rsp_rdata", rsp_rdata_o, wr ? 32'd0 : rd_data[r_idx]);
        end
        r_idx++;
        if (rsp_last_o) got_last = 1;
      end
      check("req_ready", 32'(req_ready_o), 32'(got_last));
      check("hsel", 32'(fmhsel_o), 32'(!got_last));
      e_ack = mfhready_i && (fmhtrans_o != 2'b00) && wr;
      check("wd_ack", 32'(wd_ack_o), 32'(e_ack));
      if (wd_ack_o) ack_n++;
      if (dp_act && dp_beat == err_beat && errph) check("trans_idle_err2", 32'(fmhtrans_o), 32'd0);
      new_dp = 0;
      if (mfhready_i && fmhtrans_o != 2'b00) begin
        check("addr_phase_in_range", 32'(a_idx < n_eff), 32'd1);
        if (a_idx < n) begin
          ea = base + 32'(4 * a_idx);
          et = (a_idx == 0 || ea[9:0] == 10'd0) ? 2'b10 : 2'b11;
          check("haddr", fmhaddr_o, ea);
          check("htrans", 32'(fmhtrans_o), 32'(et));
          check("hwrite", 32'(fmhwrite_o), 32'(wr));
          check("hburst", 32'(fmhburst_o), (n == 1) ? 32'd0 : 32'd1);
          check("hsize", 32'(fmhsize_o), 32'd2);
        end
        new_dp = 1;
        nb = a_idx;
        a_idx++;
      end
      if (dp_act) begin
        if (mfhready_i) begin
          if (wr && dp_beat != err_beat) check("hwdata", fmhwdata_o, wr_data[dp_beat]);
          dp_act = 0;
        end else if (dp_beat == err_beat) begin
          errph = 1;
        end else begin
          wl--;
        end
      end
      if (new_dp) begin
        dp_act  = 1;
        dp_beat = nb;
        wl      = (nb < 16) ? wait_cnt[nb] : 0;
        errph   = 0;
      end
      if (abort_after >= 0 && a_idx >= abort_after) break;
    end
    obs_nrsp = r_idx;
    obs_cyc  = cyc;
    if (abort_after < 0) begin
      check("cmd_done_in_budget", 32'(got_last), 32'd1);
      check("rsp_count", 32'(r_idx), 32'(n_eff));
      check("addr_phase_count", 32'(a_idx), 32'(n_eff));
      check("wd_ack_count", 32'(ack_n), wr ? 32'(n_eff) : 32'd0);
      check("latency", 32'(cyc), 32'(exp_cyc));
    end
  endtask

  task automatic set_beats(input int waits);
    for (int b = 0; b < 16; b++) begin
      wait_cnt[b] = waits;
      wr_data[b]  = 32'h11 * 32'(b + 1);
      rd_data[b]  = 32'hDEAD_BEEF + 32'(b);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 32'h2000_0010, 0,  2, -1, 1,  5};
    tbl[1] = '{1'b1, 32'h2000_0000, 3,  0, -1, 4,  6};
    tbl[2] = '{1'b0, 32'h2000_03F8, 15, 0, -1, 16, 18};
    tbl[3] = '{1'b0, 32'h2000_0100, 7,  0, 2,  3,  6};
    tbl[4] = '{1'b1, 32'h2000_03FC, 1,  1, -1, 2,  6};
    tbl[5] = '{1'b0, 32'h2000_0800, 0,  0, 0,  1,  4};
    tbl[6] = '{1'b1, 32'h2000_0A00, 2,  1, 2,  3,  8};

    HRESETN = 1'b0;
    repeat (3) @(negedge HCLK);
    #1 check_reset("reset");
    @(negedge HCLK);
    HRESETN = 1'b1;

    for (int i = 0; i < 7; i++) begin
      set_beats(tbl[i].waits);
      run_cmd(tbl[i].wr, tbl[i].addr, tbl[i].len, tbl[i].err_beat, 1'b0, 1'b0, -1);
      check("tbl_nrsp", 32'(obs_nrsp), 32'(tbl[i].exp_nrsp));
      check("tbl_cycles", 32'(obs_cyc), 32'(tbl[i].exp_cyc));
    end

    // Back-to-back: the held request must wait for the previous last response.
    set_beats(0);
    run_cmd(1'b0, 32'h2000_0040, 2, -1, 1'b0, 1'b1, -1);
    run_cmd(1'b0, 32'h2000_0040, 2, -1, 1'b1, 1'b0, -1);

    // Reset while the 8-beat write is on beat 5.
    set_beats(0);
    run_cmd(1'b1, 32'h2000_0200, 7, -1, 1'b0, 1'b0, 5);
    #2 HRESETN = 1'b0;
    #1 check_reset("rst_mid");
    @(negedge HCLK);
    #1 check_reset("rst_held");
    HRESETN = 1'b1;
    req_valid_i = 1'b0;
    set_beats(1);
    run_cmd(1'b0, 32'h2000_0010, 0, -1, 1'b0, 1'b0, -1);

    for (int k = 0; k < 25; k++) begin
      bit          wr;
      int          len, eb;
      logic [31:0] a;
      wr  = 1'($urandom_range(0, 1));
      len = $urandom_range(0, 15);
      a   = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 1) == 1) a[9:0] = 10'h3C0 + 10'(4 * $urandom_range(0, 15));
      eb  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
      for (int b = 0; b < 16; b++) begin
        wait_cnt[b] = $urandom_range(0, 2);
        wr_data[b]  = $urandom;
        rd_data[b]  = $urandom;
      end
      run_cmd(wr, a, len, eb, 1'b0, 1'b0, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
